operand_stage: RTL
==================

# operand_stage

Parametrised operand register stage between the register file / instruction ROM and the ALU. It generalises the fixed two-input operand latch to configurable width and any number of B-operand sources. It adds ALU-result forwarding into either operand and a valid/ready handshake with a two-entry skid buffer, so back-pressure from the ALU never drops or reorders operand pairs.

## Interface
- WIDTH, 8, operand width in bits (≥1)
- NSRC, 4, number of B-operand sources (≥1); SELW = max(1, clog2(NSRC))
- clk  in  1  rising-edge clock
- rst_n  in  1  one clock; reset is synchronous and active-low
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- da  in  WIDTH  A-operand source
- src_b  in  NSRC*WIDTH  packed B sources; source k = src_b[k*WIDTH +: WIDTH] (convention: 0 = register file, 1 = ROM immediate)
- sel_b  in  SELW  B-source select
- fwd_a  in  1  replace A operand with forwarded result
- fwd_b  in  1  replace B operand with forwarded result (overrides sel_b)
- res_valid  in  1  ALU result write strobe
- res  in  WIDTH  ALU result
- out_valid  out  1  dataa/datab hold a valid pair
- out_ready  in  1  ALU consumes pair this cycle
- dataa  out  WIDTH  registered A operand
- datab  out  WIDTH  registered B operand
- err_sel  out  1  sticky: an accepted beat had sel_b ≥ NSRC

## Operation
- Accept: in_valid & in_ready at a rising edge. Drain: out_valid & out_ready at a rising edge.
- Feedback register fb: loads res on every edge with res_valid = 1. Reset value 0.
- Forward value: fv = res when res_valid = 1 in the accept cycle (same-cycle bypass); otherwise fv = fb.
- Operand A: fwd_a ? fv : da.
- Operand B priority:
  - fwd_b = 1: fv.
  - sel_b < NSRC: source sel_b.
  - otherwise: all zeros, and err_sel is set.
- Operands are resolved in the accept cycle. Later changes to fb do not alter a captured pair.
- Storage: output register (out_valid, dataa, datab) plus one skid entry (skid_valid, skid_a, skid_b).
- in_ready = !skid_valid. This is a pure function of the register state, with no combinational path from out_ready.
- Per-edge update rules:
  - Output empty, or draining while the skid is empty: an accepted beat loads the output register. With no accept, out_valid follows (out_valid & !out_ready).
  - Output full and not draining: an accepted beat loads the skid, and skid_valid becomes 1.
  - Draining while the skid is full: the skid entry moves to the output register and skid_valid becomes 0. No accept is possible in this case, because in_ready = 0.
- Order is strictly FIFO; capacity is 2 beats.
- Simultaneous accept and drain with the skid empty: the new beat replaces the output, and out_valid stays 1.
- dataa/datab hold their value while out_valid & !out_ready. After a drain with nothing behind, they keep their last value and out_valid = 0.
- err_sel is cleared only by reset.

## Timing
- Reset (rst_n = 0 at an edge): out_valid = 0, dataa = datab = 0, skid_valid = 0, fb = 0, err_sel = 0.
- in_ready = 1 from the first cycle after reset.
- Beats presented while rst_n = 0 are discarded.
- Reset asserted mid-stall discards both stored beats.
- Latency: accept at edge N gives out_valid = 1 after edge N (with the skid empty).
- Throughput: 1 beat/cycle with out_ready held at 1.
- in_ready falls the cycle after the skid fills and rises the cycle after the skid drains.
- Forwarding: a result with res_valid at edge N is usable by a beat accepted at edge N (bypass) or at any later edge (via fb).

## Test plan
- Reset then streaming, WIDTH=8, NSRC=4: da=0x11, src_b={0x44,0x33,0x22,0x55}, sel_b=1, out_ready=1 -> one cycle later dataa=0x11, datab=0x22, out_valid=1; every output is 0 right after reset.
- Back-pressure: three beats A=1,2,3 with out_ready=0 -> beats 1 and 2 accepted, in_ready=0, and beat 3 held upstream. Then raise out_ready -> outputs 1,2,3 in order with no loss.
- Forwarding bypass: res=0x7E, res_valid=1 in the same cycle as an accept with fwd_a=1, fwd_b=1 -> dataa=datab=0x7E. The next beat, with res_valid=0 and fwd_a=1, gets dataa=0x7E from fb.
- Invalid select, NSRC=3, sel_b=3 -> datab=0x00 and err_sel=1. err_sel stays 1 across later valid beats until rst_n=0.
- Reset mid-stall: skid full, rst_n=0 for one edge -> out_valid=0, in_ready=1, and no stale beat appears afterward.
- Parameter sweep: WIDTH=16, NSRC=1 (SELW=1), sel_b=0 -> datab=src_b[15:0]; sel_b=1 -> 0 with err_sel=1.

Source files
------------

// File: rtl/operand_if.sv
// Operand stage bus: upstream beat (sources, selects, forwarding), ALU result feedback,
// and the downstream operand pair with its handshake.
interface operand_if #(
    parameter int WIDTH = 8,
    parameter int NSRC  = 4,
    parameter int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      da;
    logic [NSRC*WIDTH-1:0] src_b;
    logic [SELW-1:0]       sel_b;
    logic                  fwd_a;
    logic                  fwd_b;
    logic                  res_valid;
    logic [WIDTH-1:0]      res;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      dataa;
    logic [WIDTH-1:0]      datab;
    logic                  err_sel;

    // A beat moves when valid and ready are both high at a rising edge. in_ready
    // never depends on in_valid; out_valid never depends on out_ready.
    modport slave (
        input  in_valid, da, src_b, sel_b, fwd_a, fwd_b, res_valid, res, out_ready,
        output in_ready, out_valid, dataa, datab, err_sel
    );

    modport master (
        output in_valid, da, src_b, sel_b, fwd_a, fwd_b, res_valid, res, out_ready,
        input  in_ready, out_valid, dataa, datab, err_sel
    );
endinterface

// File: rtl/operand_stage.sv
// Operand register stage: resolves A/B operands (source select + result forwarding)
// at accept time and holds them in an output register backed by one skid entry.
module operand_stage #(
    parameter int WIDTH = 8,
    parameter int NSRC  = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    operand_if.slave  bus
);
    localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [WIDTH-1:0] fb;
    logic [WIDTH-1:0] fv;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] picked;
    logic             sel_ok;
    logic             accept;
    logic             drain;
    logic             out_valid;
    logic [WIDTH-1:0] dataa;
    logic [WIDTH-1:0] datab;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_a;
    logic [WIDTH-1:0] skid_b;
    logic             err_sel;

    // Same-cycle bypass: a result strobed this cycle wins over the stored copy.
    assign fv     = bus.res_valid ? bus.res : fb;
    assign sel_ok = (32'(bus.sel_b) < NSRC);

    always_comb begin
        picked = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.sel_b == SELW'(k)) begin
                picked = bus.src_b[k*WIDTH +: WIDTH];
            end
        end
    end

    assign op_a = bus.fwd_a ? fv : bus.da;
    assign op_b = bus.fwd_b ? fv : (sel_ok ? picked : '0);

    assign bus.in_ready = !skid_valid;
    assign accept       = bus.in_valid && !skid_valid;
    assign drain        = out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb         <= '0;
            out_valid  <= 1'b0;
            dataa      <= '0;
            datab      <= '0;
            skid_valid <= 1'b0;
            skid_a     <= '0;
            skid_b     <= '0;
            err_sel    <= 1'b0;
        end else begin
            if (bus.res_valid) begin
                fb <= bus.res;
            end
            if (accept && !bus.fwd_b && !sel_ok) begin
                err_sel <= 1'b1;
            end
            if (skid_valid) begin
                // in_ready is low here, so the only movement is skid -> output.
                if (drain) begin
                    dataa      <= skid_a;
                    datab      <= skid_b;
                    skid_valid <= 1'b0;
                end
            end else if (!out_valid || bus.out_ready) begin
                if (accept) begin
                    dataa     <= op_a;
                    datab     <= op_b;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_a     <= op_a;
                skid_b     <= op_b;
                skid_valid <= 1'b1;
            end
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.dataa     = dataa;
    assign bus.datab     = datab;
    assign bus.err_sel   = err_sel;
endmodule
